// File: rtl/mod_down_counter_if.sv
// Bundles the control inputs and count outputs of mod_down_counter.
// Signals only; no latency.
// No backpressure: the counter acts on its inputs on every clock edge.
// Optional macro MOD_DOWN_COUNTER_GRAY_OUT_EN adds the q_gray output.
interface mod_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;
`ifdef MOD_DOWN_COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] q_gray;

    modport master (output en, load, load_val, oneshot, input q, tc, done, q_gray);
    modport slave  (input en, load, load_val, oneshot, output q, tc, done, q_gray);
`else
    modport master (output en, load, load_val, oneshot, input q, tc, done);
    modport slave  (input en, load, load_val, oneshot, output q, tc, done);
`endif
endinterface

// File: rtl/mod_down_counter.sv
// Modulo-MODULUS down counter with clamped parallel load, enable, terminal count and one-shot halt.
// Latency: q/done/q_gray update one edge after inputs; tc is combinational from en, q and state.
// No backpressure; optional Gray output under macro MOD_DOWN_COUNTER_GRAY_OUT_EN.
module mod_down_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic              clk,
    input  logic              rst,
    mod_down_counter_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    // Highest legal count; MODULUS may equal 2**WIDTH so this always fits in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    // Next-state logic, priority: load > count > hold (reset handled in the flops).
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = done_q;
        if (bus.load) begin
            // Out-of-range loads clamp to the top of the count range.
            q_d     = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
            state_d = RUN;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && bus.en) begin
            if (q_q != '0) begin
                q_d = q_q - WIDTH'(1);
            end else if (bus.oneshot) begin
                // q stays at zero; only load or reset leaves HALTED.
                state_d = HALTED;
                done_d  = 1'b1;
            end else begin
                q_d = MAX_VAL;
            end
        end
    end

`ifdef MOD_DOWN_COUNTER_GRAY_OUT_EN
    localparam logic [WIDTH-1:0] MAX_GRAY = MAX_VAL ^ (MAX_VAL >> 1);

    logic [WIDTH-1:0] q_gray_q, q_gray_d;

    // Gray encoding taken from the next count so the register lines up with q.
    always_comb begin
        q_gray_d = q_d ^ (q_d >> 1);
    end

    // Gray output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_gray_q <= MAX_GRAY;
        end else begin
            q_gray_q <= q_gray_d;
        end
    end

    assign bus.q_gray = q_gray_q;
`endif

    // Counter state, count and done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            q_q     <= MAX_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.done = done_q;
    // Terminal count flags the cycle whose edge will wrap or halt.
    assign bus.tc   = bus.en & (q_q == '0) & (state_q == RUN);

endmodule

// File: tb/tb_mod_down_counter.sv
// Scoreboard bench for mod_down_counter (mod-16 instance A plus a mod-10 instance B for clamping).
// Stimulus pushes the hand-computed expected outputs for the current cycle; a monitor checks them at negedge.
// The Gray output is checked when MOD_DOWN_COUNTER_GRAY_OUT_EN is defined.
module tb_mod_down_counter;

    logic clk;
    logic rst;

    mod_down_counter_if #(.WIDTH(4)) ifa ();
    mod_down_counter_if #(.WIDTH(4)) ifb ();

    mod_down_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mod_down_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       done;
        logic       bv;
        logic [3:0] qb;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, record the expected outputs for this cycle, advance.
    task automatic cyc(input logic r, input logic e, input logic l, input logic [3:0] lv,
                       input logic os, input logic [3:0] eq, input logic etc, input logic edone,
                       input string nm, input logic bv = 1'b0, input logic [3:0] qb = 4'd0);
        exp_t x;
        rst          = r;
        ifa.en       = e;  ifb.en       = e;
        ifa.load     = l;  ifb.load     = l;
        ifa.load_val = lv; ifb.load_val = lv;
        ifa.oneshot  = os; ifb.oneshot  = os;
        x.q = eq; x.tc = etc; x.done = edone; x.bv = bv; x.qb = qb; x.nm = nm;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the counter presents its outputs every cycle; compare against any pending expectation.
    initial begin : monitor
        exp_t       e;
        logic       have_prev;
        logic [3:0] prev_q;
        logic [3:0] prev_g;
        logic [3:0] exp_g;
        have_prev = 1'b0;
        prev_q    = 4'd0;
        prev_g    = 4'd0;
        exp_g     = 4'd0;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.nm, "_q"},    32'(ifa.q),    32'(e.q));
                check({e.nm, "_tc"},   32'(ifa.tc),   32'(e.tc));
                check({e.nm, "_done"}, 32'(ifa.done), 32'(e.done));
                if (e.bv) check({e.nm, "_qb"}, 32'(ifb.q), 32'(e.qb));
`ifdef MOD_DOWN_COUNTER_GRAY_OUT_EN
                exp_g = e.q ^ (e.q >> 1);
                check({e.nm, "_gray"}, 32'(ifa.q_gray), 32'(exp_g));
                if (have_prev && (((prev_q - e.q) & 4'hF) == 4'd1))
                    check({e.nm, "_gray_1bit"}, 32'($countones(prev_g ^ ifa.q_gray)), 32'd1);
                prev_g = ifa.q_gray;
`endif
                prev_q    = e.q;
                have_prev = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        ifa.en = 1'b0; ifa.load = 1'b0; ifa.load_val = 4'd0; ifa.oneshot = 1'b0;
        ifb.en = 1'b0; ifb.load = 1'b0; ifb.load_val = 4'd0; ifb.oneshot = 1'b0;
        @(posedge clk);
        #1;

        // Reset state of both instances.
        cyc(1, 0, 0, 4'd0, 0, 4'd15, 0, 0, "rst_init", 1, 4'd9);
        cyc(1, 0, 0, 4'd0, 0, 4'd15, 0, 0, "rst_init", 1, 4'd9);

        // Continuous wrap: 15..0,15,14,13,12 with tc only at 0.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = 4'(15 - i);
            cyc(0, 1, 0, 4'd0, 0, v, (v == 4'd0), 0, "wrap");
        end

        // Enable gating from q=6: en 1,0,0,1 -> 5,5,5,4.
        cyc(0, 0, 1, 4'd6,  0, 4'd11, 0, 0, "gate_pre");
        cyc(0, 1, 0, 4'd0,  0, 4'd6,  0, 0, "gate");
        cyc(0, 0, 0, 4'd0,  0, 4'd5,  0, 0, "gate");
        cyc(0, 0, 0, 4'd0,  0, 4'd5,  0, 0, "gate");
        cyc(0, 1, 0, 4'd0,  0, 4'd5,  0, 0, "gate");
        cyc(0, 0, 1, 4'd10, 0, 4'd4,  0, 0, "gate");

        // Load beats count: load 7 with en=1 at q=10.
        cyc(0, 1, 1, 4'd7, 0, 4'd10, 0, 0, "load_pri");
        cyc(0, 0, 1, 4'd3, 1, 4'd7,  0, 0, "load_pri");

        // One-shot from 3: 3,2,1,0 then halted, en ignored.
        cyc(0, 1, 0, 4'd0, 1, 4'd3, 0, 0, "oneshot");
        cyc(0, 1, 0, 4'd0, 1, 4'd2, 0, 0, "oneshot");
        cyc(0, 1, 0, 4'd0, 1, 4'd1, 0, 0, "oneshot");
        cyc(0, 1, 0, 4'd0, 1, 4'd0, 1, 0, "oneshot_tc");
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 4'd0, i[0], 4'd0, 0, 1, "halted");

        // Load out of HALTED resumes counting.
        cyc(0, 0, 1, 4'd9, 1, 4'd0, 0, 1, "halt_load");
        cyc(0, 1, 0, 4'd0, 1, 4'd9, 0, 0, "halt_load");

        // Load 0 with oneshot and en: next edge halts, tc one cycle.
        cyc(0, 1, 1, 4'd0, 1, 4'd8, 0, 0, "load0");
        cyc(0, 1, 0, 4'd0, 1, 4'd0, 1, 0, "load0");
        cyc(0, 1, 0, 4'd0, 1, 4'd0, 0, 1, "load0");

        // oneshot dropped before reaching zero: wraps instead of halting.
        cyc(0, 0, 1, 4'd1, 1, 4'd0,  0, 1, "os_change");
        cyc(0, 1, 0, 4'd0, 1, 4'd1,  0, 0, "os_change");
        cyc(0, 1, 0, 4'd0, 0, 4'd0,  1, 0, "os_change");
        cyc(0, 1, 0, 4'd0, 0, 4'd15, 0, 0, "os_change");

        // Asynchronous reset mid-count at q=5, held two cycles.
        cyc(0, 0, 1, 4'd5, 0, 4'd14, 0, 0, "rst_mid");
        cyc(0, 0, 0, 4'd0, 0, 4'd5,  0, 0, "rst_mid");
        cyc(1, 1, 0, 4'd0, 0, 4'd15, 0, 0, "rst_async");
        cyc(1, 1, 0, 4'd0, 0, 4'd15, 0, 0, "rst_async");
        cyc(0, 1, 0, 4'd0, 0, 4'd15, 0, 0, "rst_rel");
        cyc(0, 0, 0, 4'd0, 0, 4'd14, 0, 0, "rst_rel");

        // Clamp on the mod-10 instance: 12 -> 9, 15 -> 9; wrap 0 -> 9.
        cyc(0, 0, 1, 4'd12, 0, 4'd14, 0, 0, "clamp");
        cyc(0, 0, 1, 4'd15, 0, 4'd12, 0, 0, "clamp", 1, 4'd9);
        cyc(0, 1, 0, 4'd0,  0, 4'd15, 0, 0, "clamp", 1, 4'd9);
        cyc(0, 0, 1, 4'd0,  0, 4'd14, 0, 0, "clamp", 1, 4'd8);
        cyc(0, 1, 0, 4'd0,  0, 4'd0,  1, 0, "clamp_wrap", 1, 4'd0);
        cyc(0, 0, 0, 4'd0,  0, 4'd15, 0, 0, "clamp_wrap", 1, 4'd9);

        @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
